mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipeline, directly downstream of execute. Consumes the EX/MEM latch outputs, performs loads and stores against a multi-cycle data memory over a request/done handshake, and drives the MEM/WB pipeline registers consumed by writeback. While a memory transaction is outstanding, it raises a stall so that upstream stages hold, and it injects bubbles into MEM/WB.

## Interface
Parameters:
- MAX_WAIT, 15: maximum WAIT cycles before a transaction is abandoned with err (4-bit counter).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ALUO_EXMEM  in  16  ALU result; memory address for loads and stores.
- Rd2_EXMEM  in  16  store data.
- WrR_EXMEM  in  3  destination register.
- MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM  in  1 each  control from execute.
- mem_Addr  out  16  address to data memory; equals ALUO_EXMEM.
- mem_DataIn  out  16  write data; equals Rd2_EXMEM.
- mem_Rd, mem_Wr  out  1 each  one-cycle request strobes.
- mem_DataOut  in  16  read data; valid only when mem_Done=1.
- mem_Done  in  1  one-cycle completion pulse for the current request.
- ALUO_MEMWB, MemData_MEMWB  out  16 each  registered ALU result and load data.
- WrR_MEMWB  out  3  registered destination register.
- RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB  out  1 each  registered controls.
- Stall_MEM  out  1  combinational; holds IF/ID/EX/EXMEM while high.
- err  out  1  registered; sticky until reset.

## Operation
- Access = MemRead_EXMEM | MemWrite_EXMEM. MemRead and MemWrite both high is illegal: err is set and no request is issued.
- Unaligned access (access with ALUO_EXMEM[0]=1) sets err, issues no request, and passes a bubble.
- FSM has 2 states, IDLE and WAIT.
- IDLE, no access: MEM/WB loads the EX/MEM values every cycle. Stall_MEM=0.
- IDLE, access: assert mem_Rd or mem_Wr for this cycle only.
  - If mem_Done=1 in the same cycle (hit), MEM/WB loads, MemData_MEMWB=mem_DataOut, Stall_MEM=0, and the FSM stays in IDLE.
  - Otherwise Stall_MEM=1, the FSM goes to WAIT, the counter clears to 0, and MEM/WB loads a bubble.
- WAIT: no strobes are asserted and mem_Addr/mem_DataIn stay stable, because EX/MEM is held.
  - mem_Done=1: MEM/WB loads with data, Stall_MEM=0 this cycle, next state IDLE.
  - Otherwise Stall_MEM=1, the counter increments, and MEM/WB loads a bubble.
  - Counter reaches MAX_WAIT without mem_Done: set err, Stall_MEM=0, the instruction is dropped as a bubble, next state IDLE.
- Bubble: RegWrite_MEMWB=0, MemtoReg_MEMWB=0, Dump_MEMWB=0. Data fields are don't-care but are driven to 0.
- Stores write no register unless RegWrite_EXMEM=1. MemData_MEMWB is 0 for non-loads.
- A mem_Done received in IDLE with no request pending is ignored.

## Timing
- Reset value of every registered output is 0, and the FSM resets to IDLE with counter 0. Reset during WAIT abandons the transaction.
- Hit latency: MEM/WB is valid one edge after the request cycle. Miss with Done in WAIT cycle k: valid at edge k+1 after the request, with Stall_MEM high for k cycles.
- Stall_MEM is combinational from state, access and mem_Done. It never depends on MEM/WB.
- At most one outstanding request. A new request can only be issued from IDLE.

## Structure
- Shared pipeline package holds:
  - the state encoding (IDLE=1'b0, WAIT=1'b1);
  - the bubble constant;
  - the default for MAX_WAIT.
- MEM/WB latches use the existing reg16bit/reg3bit register cells with en=1.
- One sub-module, mem_wait_ctr: a 4-bit counter with clear/increment and terminal-count output.

## Test plan
- Non-memory op: ALUO_EXMEM=0x1234, RegWrite=1, WrR=5 -> next edge ALUO_MEMWB=0x1234, RegWrite_MEMWB=1, WrR_MEMWB=5, Stall_MEM=0 throughout.
- Load hit: MemRead=1, addr 0x0040, mem_Done=1 with data 0xBEEF in the request cycle -> mem_Rd high 1 cycle, MemData_MEMWB=0xBEEF, MemtoReg_MEMWB=1, no stall.
- Store miss: MemWrite=1, addr 0x0010, data 0x00AA, mem_Done on 3rd WAIT cycle -> mem_Wr high 1 cycle, Stall_MEM high 3 cycles, 3 bubbles, RegWrite_MEMWB=0.
- Unaligned load at 0x0041 -> no mem_Rd, err=1 next edge and stays 1, MEM/WB bubble.
- Timeout: load issued, mem_Done never asserted -> after 15 WAIT cycles err=1, FSM back to IDLE, Stall_MEM drops, and a subsequent ALU op flows through normally.
- Reset in 2nd WAIT cycle -> next edge all outputs 0, IDLE. A late mem_Done pulse is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared pipeline definitions for the memory stage: FSM encoding,
//            MEM/WB bundle, bubble constant and wait-limit default.
// Revision : 1.0
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] mem_data;
    logic [2:0]  wr_reg;
    logic        reg_write;
    logic        mem_to_reg;
    logic        dump;
  } memwb_t;

  localparam memwb_t     c_bubble   = '0;
  localparam logic [3:0] c_max_wait = 4'd15;

  function automatic memwb_t make_memwb(
    input logic [15:0] alu,
    input logic [15:0] mem_data,
    input logic [2:0]  wr_reg,
    input logic        reg_write,
    input logic        mem_to_reg,
    input logic        dump
  );
    memwb_t r;
    r.alu        = alu;
    r.mem_data   = mem_data;
    r.wr_reg     = wr_reg;
    r.reg_write  = reg_write;
    r.mem_to_reg = mem_to_reg;
    r.dump       = dump;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_ctr
// Brief    : 4-bit wait counter with clear/increment and terminal-count flag.
// Revision : 1.0
// ============================================================================
module mem_wait_ctr #(
  parameter logic [3:0] TERMINAL = 4'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc)   r_cnt <= r_cnt + 4'd1;
  end

  assign o_tc = (r_cnt == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/reg16bit.sv
`default_nettype none
// ============================================================================
// Module   : reg16bit
// Brief    : 16-bit pipeline register cell with enable and synchronous reset.
// Revision : 1.0
// ============================================================================
module reg16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/reg3bit.sv
`default_nettype none
// ============================================================================
// Module   : reg3bit
// Brief    : 3-bit pipeline register cell with enable and synchronous reset.
// Revision : 1.0
// ============================================================================
module reg3bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);

  logic [2:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage; drives a multi-cycle data memory over a
//            request/done handshake and loads the MEM/WB registers.
// Revision : 1.0
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [3:0] MAX_WAIT = c_max_wait
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        Dump_EXMEM,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        mem_Rd,
  output logic        mem_Wr,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  output logic [15:0] ALUO_MEMWB,
  output logic [15:0] MemData_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        Dump_MEMWB,
  output logic        Stall_MEM,
  output logic        err
);

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;
  memwb_t      w_memwb;
  memwb_t      w_pass_plain;
  memwb_t      w_pass_data;
  logic        w_access;
  logic        w_bad;
  logic        w_clr;
  logic        w_inc;
  logic        w_tc;
  logic        w_set_err;
  logic [15:0] w_load_data;
  logic        r_err;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_dump;

  assign mem_Addr    = ALUO_EXMEM;
  assign mem_DataIn  = Rd2_EXMEM;
  assign w_access    = MemRead_EXMEM | MemWrite_EXMEM;
  assign w_bad       = (MemRead_EXMEM & MemWrite_EXMEM) | ALUO_EXMEM[0];
  assign w_load_data = MemRead_EXMEM ? mem_DataOut : 16'h0000;

  assign w_pass_plain = make_memwb(ALUO_EXMEM, 16'h0000, WrR_EXMEM,
                                   RegWrite_EXMEM, MemtoReg_EXMEM, Dump_EXMEM);
  assign w_pass_data  = make_memwb(ALUO_EXMEM, w_load_data, WrR_EXMEM,
                                   RegWrite_EXMEM, MemtoReg_EXMEM, Dump_EXMEM);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_memwb     = c_bubble;
    mem_Rd      = 1'b0;
    mem_Wr      = 1'b0;
    Stall_MEM   = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_access) begin
          w_memwb = w_pass_plain;
        end else if (w_bad) begin
          w_set_err = 1'b1;
        end else begin
          mem_Rd = MemRead_EXMEM;
          mem_Wr = MemWrite_EXMEM;
          if (mem_Done) begin
            w_memwb = w_pass_data;
          end else begin
            Stall_MEM   = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // A completion on the terminal cycle still wins over the timeout.
        if (mem_Done) begin
          w_memwb     = w_pass_data;
          w_state_nxt = IDLE;
        end else if (w_tc) begin
          w_set_err   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          Stall_MEM = 1'b1;
          w_inc     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  mem_wait_ctr #(
    .TERMINAL (MAX_WAIT)
  ) u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_tc  (w_tc)
  );

  reg16bit u_alu_memwb (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_memwb.alu),
    .o_q  (ALUO_MEMWB)
  );

  reg16bit u_data_memwb (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_memwb.mem_data),
    .o_q  (MemData_MEMWB)
  );

  reg3bit u_wrr_memwb (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_memwb.wr_reg),
    .o_q  (WrR_MEMWB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_dump       <= 1'b0;
    end else begin
      r_err        <= r_err | w_set_err;
      r_reg_write  <= w_memwb.reg_write;
      r_mem_to_reg <= w_memwb.mem_to_reg;
      r_dump       <= w_memwb.dump;
    end
  end

  assign err            = r_err;
  assign RegWrite_MEMWB = r_reg_write;
  assign MemtoReg_MEMWB = r_mem_to_reg;
  assign Dump_MEMWB     = r_dump;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Scoreboard bench for mem_stage with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

  localparam int MW    = 15;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM, mem_DataOut;
  logic [2:0]  WrR_EXMEM;
  logic        MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM;
  logic        mem_Done;
  logic [15:0] mem_Addr, mem_DataIn, ALUO_MEMWB, MemData_MEMWB;
  logic [2:0]  WrR_MEMWB;
  logic        mem_Rd, mem_Wr, RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB, Stall_MEM, err;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4'(MW))) dut (
    .clk(clk), .rst(rst),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .WrR_EXMEM(WrR_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .MemtoReg_EXMEM(MemtoReg_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
    .Dump_EXMEM(Dump_EXMEM),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done),
    .ALUO_MEMWB(ALUO_MEMWB), .MemData_MEMWB(MemData_MEMWB), .WrR_MEMWB(WrR_MEMWB),
    .RegWrite_MEMWB(RegWrite_MEMWB), .MemtoReg_MEMWB(MemtoReg_MEMWB),
    .Dump_MEMWB(Dump_MEMWB), .Stall_MEM(Stall_MEM), .err(err)
  );

  typedef struct {
    int          stamp;
    logic        stall, rd, wr;
    logic [15:0] addr, din;
  } comb_t;

  typedef struct {
    int          stamp;
    logic [15:0] alu, md;
    logic [2:0]  wrr;
    logic        rw, m2r, dump, err;
  } reg_t;

  comb_t q_comb[$];
  reg_t  q_reg[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  logic  err_m  = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic reg_t mk(input logic [15:0] alu, input logic [15:0] md,
                              input logic [2:0] wrr, input logic rw, input logic m2r,
                              input logic dump, input logic e);
    reg_t r;
    r.stamp = 0; r.alu = alu; r.md = md; r.wrr = wrr;
    r.rw = rw; r.m2r = m2r; r.dump = dump; r.err = e;
    return r;
  endfunction

  // Monitor: comb expectations belong to the current cycle, register
  // expectations to the cycle after the edge that loaded them.
  always @(negedge clk) begin
    comb_t c;
    reg_t  r;
    while (q_comb.size() > 0 && q_comb[0].stamp <= cyc) begin
      c = q_comb.pop_front();
      chk("stall",  {15'h0, Stall_MEM}, {15'h0, c.stall});
      chk("mem_rd", {15'h0, mem_Rd},    {15'h0, c.rd});
      chk("mem_wr", {15'h0, mem_Wr},    {15'h0, c.wr});
      chk("addr",   mem_Addr,   c.addr);
      chk("datain", mem_DataIn, c.din);
    end
    while (q_reg.size() > 0 && q_reg[0].stamp <= cyc) begin
      r = q_reg.pop_front();
      chk("alu_memwb",  ALUO_MEMWB,    r.alu);
      chk("data_memwb", MemData_MEMWB, r.md);
      chk("wrr_memwb",  {13'h0, WrR_MEMWB},      {13'h0, r.wrr});
      chk("rw_memwb",   {15'h0, RegWrite_MEMWB}, {15'h0, r.rw});
      chk("m2r_memwb",  {15'h0, MemtoReg_MEMWB}, {15'h0, r.m2r});
      chk("dump_memwb", {15'h0, Dump_MEMWB},     {15'h0, r.dump});
      chk("err",        {15'h0, err},            {15'h0, r.err});
    end
  end

  task automatic step(input logic done, input logic [15:0] data, input bit do_comb,
                      input logic stall, input logic rd, input logic wr, input reg_t er);
    mem_Done    = done;
    mem_DataOut = data;
    if (do_comb) q_comb.push_back('{cyc, stall, rd, wr, ALUO_EXMEM, Rd2_EXMEM});
    er.stamp = cyc + 1;
    q_reg.push_back(er);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_exmem(input logic [15:0] alu, input logic [15:0] rd2, input logic [2:0] wrr,
                           input logic mr, input logic mw, input logic m2r, input logic rw,
                           input logic dump);
    ALUO_EXMEM = alu; Rd2_EXMEM = rd2; WrR_EXMEM = wrr;
    MemRead_EXMEM = mr; MemWrite_EXMEM = mw; MemtoReg_EXMEM = m2r;
    RegWrite_EXMEM = rw; Dump_EXMEM = dump;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    err_m = 1'b0;
    set_exmem(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
  endtask

  // One instruction held in EX/MEM; lat = WAIT cycle carrying mem_Done
  // (0 = same-cycle hit, anything past MW+1 = never answered).
  task automatic do_txn(input logic [15:0] alu, input logic [15:0] rd2, input logic [2:0] wrr,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic dump, input int lat);
    logic [15:0] data;
    int          ncyc;
    bit          done_ok;
    set_exmem(alu, rd2, wrr, mr, mw, m2r, rw, dump);
    data = 16'($urandom);
    if (!(mr | mw)) begin
      step($urandom_range(0, 3) == 0, data, 1'b1, 1'b0, 1'b0, 1'b0,
           mk(alu, 16'h0, wrr, rw, m2r, dump, err_m));
    end else if ((mr & mw) | alu[0]) begin
      err_m = 1'b1;
      step($urandom_range(0, 1) == 0, data, 1'b1, 1'b0, 1'b0, 1'b0,
           mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, err_m));
    end else begin
      done_ok = (lat <= MW + 1);
      ncyc    = done_ok ? lat + 1 : MW + 2;
      for (int j = 0; j < ncyc; j++) begin
        bit last;
        last = (j == ncyc - 1);
        data = 16'($urandom);
        if (last && !done_ok) err_m = 1'b1;
        step(j == lat, data, 1'b1, !last, (j == 0) && mr, (j == 0) && mw,
             (last && done_ok) ? mk(alu, mr ? data : 16'h0, wrr, rw, m2r, dump, err_m)
                               : mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, err_m));
      end
    end
  endtask

  task automatic reset_in_wait();
    reg_t bub;
    set_exmem(16'h0080, 16'h1111, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    bub = mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, err_m);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, bub);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, bub);
    rst = 1'b1;
    err_m = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    set_exmem(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    rst = 1'b1;
    mem_Done = 1'b0;
    mem_DataOut = 16'h0;
    set_exmem(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    do_reset();
    do_reset();

    do_txn(16'h1234, 16'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_txn(16'h0040, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    do_txn(16'h0010, 16'h00AA, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    do_txn(16'h0041, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    do_txn(16'h4321, 16'h0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    do_reset();
    do_txn(16'h0022, 16'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NEVER);
    do_txn(16'h5678, 16'h0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_reset();
    do_txn(16'h0030, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, MW + 1);
    do_txn(16'h0032, 16'h0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MW);
    reset_in_wait();

    for (int n = 0; n < 60; n++) begin
      int          kind, r, lat;
      logic [15:0] a;
      if (err_m && $urandom_range(0, 2) == 0) do_reset();
      kind = $urandom_range(0, 10);
      r    = $urandom_range(0, 9);
      lat  = (r < 7) ? r : (r == 7) ? MW : (r == 8) ? MW + 1 : NEVER;
      a    = 16'($urandom) & 16'hFFFE;
      case (kind)
        0, 1, 2, 3: do_txn(16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0,
                           1'($urandom), 1'($urandom), 1'($urandom), 0);
        4, 5, 6:    do_txn(a, 16'($urandom), 3'($urandom), 1'b1, 1'b0,
                           1'b1, 1'b1, 1'($urandom), lat);
        7, 8:       do_txn(a, 16'($urandom), 3'($urandom), 1'b0, 1'b1,
                           1'b0, 1'($urandom), 1'($urandom), lat);
        9:          do_txn(a | 16'h1, 16'($urandom), 3'($urandom), 1'b1, 1'b0,
                           1'b1, 1'b1, 1'b0, lat);
        default:    do_txn(a, 16'($urandom), 3'($urandom), 1'b1, 1'b1,
                           1'b1, 1'b1, 1'b0, lat);
      endcase
    end

    do_txn(16'hA5A4, 16'h0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q_comb.size() != 0 || q_reg.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_comb.size() + q_reg.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
